// File: rtl/nb_argmin_acc_if.sv
// rtl/nb_argmin_acc_if.sv - stream, prior-write and result handshake bundle for nb_argmin_acc
interface nb_argmin_acc_if #(
    parameter int CLS_W  = 4,
    parameter int DATA_W = 10,
    parameter int ACC_W  = 17
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              prior_we;
    logic [CLS_W-1:0]  prior_addr;
    logic [ACC_W-1:0]  prior_wdata;
    logic              out_valid;
    logic              out_ready;
    logic [CLS_W-1:0]  label;
    logic [ACC_W-1:0]  best_score;
    logic [ACC_W-1:0]  margin;
    logic              out_sat;

    modport slave (
        input  in_valid, in_data, prior_we, prior_addr, prior_wdata, out_ready,
        output in_ready, out_valid, label, best_score, margin, out_sat
    );

    modport master (
        output in_valid, in_data, prior_we, prior_addr, prior_wdata, out_ready,
        input  in_ready, out_valid, label, best_score, margin, out_sat
    );
endinterface

// File: rtl/nb_argmin_acc.sv
// rtl/nb_argmin_acc.sv - naive-Bayes per-class score accumulator with prior table and argmin/argmax select
module nb_argmin_acc #(
    parameter int NUM_CLASSES = 10,
    parameter int NUM_ATTRS   = 784,
    parameter int DATA_W      = 10,
    parameter int ACC_W       = 17,
    parameter int MODE        = 0,
    localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input logic           clk,
    input logic           rst,
    nb_argmin_acc_if.slave bus
);
    localparam int ATTR_W = (NUM_ATTRS > 1) ? $clog2(NUM_ATTRS) : 1;
    localparam logic [ACC_W-1:0]  ACC_MAX   = {ACC_W{1'b1}};
    localparam logic [ATTR_W-1:0] LAST_ATTR = ATTR_W'(NUM_ATTRS - 1);
    localparam logic [CLS_W-1:0]  LAST_CLS  = CLS_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {S_ACC, S_CMP, S_OUT} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_prior [NUM_CLASSES];
    logic [ACC_W-1:0]   r_acc;
    logic [ATTR_W-1:0]  r_attr_cnt;
    logic [CLS_W-1:0]   r_class_cnt;
    logic [ACC_W-1:0]   r_best;
    logic [ACC_W-1:0]   r_second;
    logic               r_second_vld;
    logic [CLS_W-1:0]   r_label;
    logic               r_sat;
    logic               r_out_valid;
    logic [CLS_W-1:0]   r_label_out;
    logic [ACC_W-1:0]   r_best_out;
    logic [ACC_W-1:0]   r_margin_out;
    logic               r_sat_out;

    logic               w_accept;
    logic               w_last_attr;
    logic [ACC_W-1:0]   w_prior_sel;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W-1:0]   w_margin;
    logic               w_better_best;
    logic               w_better_second;

    function automatic logic f_better(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
        return (MODE == 0) ? (a < b) : (a > b);
    endfunction

    always_comb begin
        w_prior_sel = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (32'(r_class_cnt) == i) w_prior_sel = r_prior[i];
        end
    end

    assign w_accept    = bus.in_valid && (r_state == S_ACC);
    assign w_last_attr = (r_attr_cnt == LAST_ATTR);
    // The first beat of a class starts from its prior instead of the running sum.
    assign w_base      = (r_attr_cnt == '0) ? w_prior_sel : r_acc;
    assign w_sum       = {1'b0, w_base} + (ACC_W+1)'(bus.in_data);
    assign w_acc_next  = w_sum[ACC_W] ? ACC_MAX : w_sum[ACC_W-1:0];

    assign w_better_best   = f_better(r_acc, r_best);
    assign w_better_second = f_better(r_acc, r_second);
    assign w_margin = (NUM_CLASSES == 1) ? ACC_MAX :
                      (r_second > r_best) ? (r_second - r_best) : (r_best - r_second);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_ACC:   if (w_accept && w_last_attr) w_state_next = S_CMP;
            S_CMP:   w_state_next = (r_class_cnt == LAST_CLS) ? S_OUT : S_ACC;
            S_OUT:   if (r_out_valid && bus.out_ready) w_state_next = S_ACC;
            default: w_state_next = S_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_ACC;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) r_prior[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (bus.prior_we && 32'(bus.prior_addr) == i) r_prior[i] <= bus.prior_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_attr_cnt   <= '0;
            r_class_cnt  <= '0;
            r_best       <= '0;
            r_second     <= '0;
            r_second_vld <= 1'b0;
            r_label      <= '0;
            r_sat        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_label_out  <= '0;
            r_best_out   <= '0;
            r_margin_out <= '0;
            r_sat_out    <= 1'b0;
        end else begin
            unique case (r_state)
                S_ACC: begin
                    if (w_accept) begin
                        r_acc      <= w_acc_next;
                        r_attr_cnt <= w_last_attr ? '0 : r_attr_cnt + ATTR_W'(1);
                        if (w_sum[ACC_W]) r_sat <= 1'b1;
                    end
                end
                S_CMP: begin
                    if (r_class_cnt == '0) begin
                        r_best       <= r_acc;
                        r_label      <= '0;
                        r_second_vld <= 1'b0;
                    end else if (w_better_best) begin
                        r_second     <= r_best;
                        r_second_vld <= 1'b1;
                        r_best       <= r_acc;
                        r_label      <= r_class_cnt;
                    end else if (w_better_second || !r_second_vld) begin
                        r_second     <= r_acc;
                        r_second_vld <= 1'b1;
                    end
                    if (r_class_cnt != LAST_CLS) r_class_cnt <= r_class_cnt + CLS_W'(1);
                end
                S_OUT: begin
                    if (!r_out_valid) begin
                        r_out_valid  <= 1'b1;
                        r_label_out  <= r_label;
                        r_best_out   <= r_best;
                        r_margin_out <= w_margin;
                        r_sat_out    <= r_sat;
                    end else if (bus.out_ready) begin
                        // Result registers except the flag keep their values until the next frame.
                        r_out_valid  <= 1'b0;
                        r_sat_out    <= 1'b0;
                        r_sat        <= 1'b0;
                        r_class_cnt  <= '0;
                        r_attr_cnt   <= '0;
                        r_acc        <= '0;
                        r_second_vld <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_ACC);
    assign bus.out_valid  = r_out_valid;
    assign bus.label      = r_label_out;
    assign bus.best_score = r_best_out;
    assign bus.margin     = r_margin_out;
    assign bus.out_sat    = r_sat_out;
endmodule

// File: tb/tb_nb_argmin_acc.sv
// tb/tb_nb_argmin_acc.sv - self-checking bench for nb_argmin_acc across three parameter sets
module tb_nb_argmin_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_err    = 0;
    int n_checks = 0;

    nb_argmin_acc_if #(.CLS_W(2), .DATA_W(10), .ACC_W(17)) ifa ();
    nb_argmin_acc_if #(.CLS_W(1), .DATA_W(8),  .ACC_W(8))  ifb ();
    nb_argmin_acc_if #(.CLS_W(4), .DATA_W(10), .ACC_W(17)) ifc ();

    nb_argmin_acc #(.NUM_CLASSES(3), .NUM_ATTRS(4), .DATA_W(10), .ACC_W(17), .MODE(0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    nb_argmin_acc #(.NUM_CLASSES(2), .NUM_ATTRS(3), .DATA_W(8), .ACC_W(8), .MODE(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    nb_argmin_acc #(.NUM_CLASSES(10), .NUM_ATTRS(784), .DATA_W(10), .ACC_W(17), .MODE(1))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: final score per class is the clamped total; winner is the first extreme value.
    task automatic ref_model(input int nc, input int accw, input int mode, input longint tot[10],
                             output int lab, output longint best, output longint mar, output bit sat);
        longint mx;
        longint sc[10];
        longint sec;
        bit     found;
        mx  = (longint'(1) << accw) - 1;
        sat = 1'b0;
        for (int c = 0; c < nc; c++) begin
            sc[c] = (tot[c] > mx) ? mx : tot[c];
            if (tot[c] > mx) sat = 1'b1;
        end
        lab = 0;
        for (int c = 1; c < nc; c++)
            if ((mode == 0) ? (sc[c] < sc[lab]) : (sc[c] > sc[lab])) lab = c;
        best  = sc[lab];
        found = 1'b0;
        sec   = 0;
        for (int c = 0; c < nc; c++) begin
            if (c != lab && (!found || ((mode == 0) ? (sc[c] < sec) : (sc[c] > sec)))) begin
                sec   = sc[c];
                found = 1'b1;
            end
        end
        mar = (nc == 1) ? mx : ((sec > best) ? sec - best : best - sec);
    endtask

    task automatic wr_prior_a(input int addr, input int val);
        ifa.prior_we    = 1'b1;
        ifa.prior_addr  = 2'(addr);
        ifa.prior_wdata = 17'(val);
        @(posedge clk); #1;
        ifa.prior_we    = 1'b0;
    endtask

    task automatic beat_a(input int d, input bit stall);
        int guard;
        if (stall) begin
            ifa.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        ifa.in_valid = 1'b1;
        ifa.in_data  = 10'(d);
        guard = 0;
        while (ifa.in_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
        if (guard >= 50) chk("beat_a_timeout", 64'(ifa.in_ready), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic frame_a(input int pri[3], input int d[12], input bit stall,
                           input bit mid_wr, input int mid_val, input int hold);
        longint tot[10];
        int     eff[3];
        int     lab;
        longint best, mar;
        bit     sat;
        eff = pri;
        for (int c = 0; c < 3; c++) wr_prior_a(c, pri[c]);
        wr_prior_a(3, 12345);
        for (int c = 0; c < 3; c++) begin
            for (int a = 0; a < 4; a++) begin
                beat_a(d[c*4+a], stall);
                if (a == 3) chk($sformatf("cmp_in_ready_c%0d", c), 64'(ifa.in_ready), 64'(0));
                if (mid_wr && c == 1 && a == 0) begin
                    ifa.in_valid = 1'b0;
                    wr_prior_a(2, mid_val);
                    eff[2] = mid_val;
                end
            end
        end
        ifa.in_valid = 1'b0;
        chk("lat_t0", 64'(ifa.out_valid), 64'(0));
        @(posedge clk); #1;
        chk("lat_t1", 64'(ifa.out_valid), 64'(0));
        @(posedge clk); #1;
        chk("lat_t2", 64'(ifa.out_valid), 64'(1));
        for (int c = 0; c < 10; c++) tot[c] = 0;
        for (int c = 0; c < 3; c++) begin
            tot[c] = eff[c];
            for (int a = 0; a < 4; a++) tot[c] += d[c*4+a];
        end
        ref_model(3, 17, 0, tot, lab, best, mar, sat);
        chk("a_label",  64'(ifa.label),      64'(lab));
        chk("a_best",   64'(ifa.best_score), 64'(best));
        chk("a_margin", 64'(ifa.margin),     64'(mar));
        chk("a_sat",    64'(ifa.out_sat),    64'(sat));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_valid", h),    64'(ifa.out_valid),  64'(1));
            chk($sformatf("hold%0d_in_ready", h), 64'(ifa.in_ready),   64'(0));
            chk($sformatf("hold%0d_label", h),    64'(ifa.label),      64'(lab));
            chk($sformatf("hold%0d_best", h),     64'(ifa.best_score), 64'(best));
            chk($sformatf("hold%0d_margin", h),   64'(ifa.margin),     64'(mar));
        end
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
        chk("rel_valid",    64'(ifa.out_valid), 64'(0));
        chk("rel_in_ready", 64'(ifa.in_ready),  64'(1));
    endtask

    initial begin
        int     d1[12];
        int     p1[3];
        int     rp[3];
        int     rd[12];
        longint tot[10];
        int     lab;
        longint best, mar;
        bit     sat;
        int     guard;

        ifa.in_valid = 0; ifa.in_data = '0; ifa.prior_we = 0; ifa.prior_addr = '0; ifa.prior_wdata = '0; ifa.out_ready = 0;
        ifb.in_valid = 0; ifb.in_data = '0; ifb.prior_we = 0; ifb.prior_addr = '0; ifb.prior_wdata = '0; ifb.out_ready = 0;
        ifc.in_valid = 0; ifc.in_data = '0; ifc.prior_we = 0; ifc.prior_addr = '0; ifc.prior_wdata = '0; ifc.out_ready = 0;
        d1 = '{1, 1, 1, 1, 2, 2, 2, 2, 0, 0, 3, 3};
        p1 = '{5, 0, 2};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready",  64'(ifa.in_ready),   64'(1));
        chk("rst_out_valid", 64'(ifa.out_valid),  64'(0));
        chk("rst_label",     64'(ifa.label),      64'(0));
        chk("rst_best",      64'(ifa.best_score), 64'(0));
        chk("rst_margin",    64'(ifa.margin),     64'(0));
        chk("rst_sat",       64'(ifa.out_sat),    64'(0));

        frame_a(p1, d1, 1'b0, 1'b0, 0, 5);
        frame_a(p1, d1, 1'b1, 1'b0, 0, 0);
        frame_a(p1, d1, 1'b0, 1'b1, 100, 0);
        frame_a(p1, d1, 1'b0, 1'b0, 0, 0);

        // Abort partway through class 1, between clock edges.
        for (int c = 0; c < 3; c++) wr_prior_a(c, p1[c]);
        for (int i = 0; i < 6; i++) beat_a(d1[i], 1'b0);
        ifa.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(ifa.out_valid),  64'(0));
        chk("arst_label",     64'(ifa.label),      64'(0));
        chk("arst_best",      64'(ifa.best_score), 64'(0));
        chk("arst_margin",    64'(ifa.margin),     64'(0));
        chk("arst_in_ready",  64'(ifa.in_ready),   64'(1));
        #2 rst = 1'b0;
        @(posedge clk); #1;
        frame_a(p1, d1, 1'b0, 1'b0, 0, 0);

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) rp[c] = (r == 2) ? int'($urandom_range(130000, 131071)) : int'($urandom_range(0, 300));
            for (int i = 0; i < 12; i++) rd[i] = int'($urandom_range(0, 1023));
            frame_a(rp, rd, 1'b1, 1'b0, 0, 2);
        end

        ifb.in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 3; a++) begin
                ifb.in_data = (c == 0) ? 8'd255 : 8'd10;
                guard = 0;
                while (ifb.in_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
                if (guard >= 50) chk("beat_b_timeout", 64'(ifb.in_ready), 64'(1));
                @(posedge clk); #1;
            end
        end
        ifb.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) tot[c] = 0;
        tot[0] = 3 * 255;
        tot[1] = 3 * 10;
        ref_model(2, 8, 0, tot, lab, best, mar, sat);
        chk("b_valid",  64'(ifb.out_valid),  64'(1));
        chk("b_label",  64'(ifb.label),      64'(lab));
        chk("b_best",   64'(ifb.best_score), 64'(best));
        chk("b_margin", 64'(ifb.margin),     64'(mar));
        chk("b_sat",    64'(ifb.out_sat),    64'(sat));
        ifb.out_ready = 1'b1;
        @(posedge clk); #1;
        ifb.out_ready = 1'b0;
        chk("b_rel_valid", 64'(ifb.out_valid), 64'(0));

        ifc.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int a = 0; a < 784; a++) begin
                ifc.in_data = (c == 7) ? 10'd1 : 10'd0;
                guard = 0;
                while (ifc.in_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
                if (guard >= 50) chk("beat_c_timeout", 64'(ifc.in_ready), 64'(1));
                @(posedge clk); #1;
            end
        end
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) tot[c] = (c == 7) ? 784 : 0;
        ref_model(10, 17, 1, tot, lab, best, mar, sat);
        chk("c_valid",  64'(ifc.out_valid),  64'(1));
        chk("c_label",  64'(ifc.label),      64'(lab));
        chk("c_best",   64'(ifc.best_score), 64'(best));
        chk("c_margin", 64'(ifc.margin),     64'(mar));
        chk("c_sat",    64'(ifc.out_sat),    64'(sat));
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        chk("c_rel_valid", 64'(ifc.out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
